// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state codes, constants and output decode for the router FSM
package router_pkg;

    localparam int STATE_WIDTH     = 3;
    localparam int ROUTER_NUM_FIFO = 3;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [STATE_WIDTH-1:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_t;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic write_enb_reg;
        logic rst_int_reg;
        logic busy;
    } router_fsm_out_t;

    function automatic router_fsm_out_t router_fsm_dec(input router_state_t st);
        router_fsm_out_t o;
        o               = '0;
        o.detect_add    = (st == DECODE_ADDRESS);
        o.lfd_state     = (st == LOAD_FIRST_DATA);
        o.ld_state      = (st == LOAD_DATA);
        o.laf_state     = (st == LOAD_AFTER_FULL);
        o.full_state    = (st == FIFO_FULL_STATE);
        o.rst_int_reg   = (st == CHECK_PARITY_ERROR);
        o.write_enb_reg = (st == LOAD_DATA) || (st == LOAD_PARITY) || (st == LOAD_AFTER_FULL);
        o.busy          = (st != DECODE_ADDRESS) && (st != LOAD_DATA);
        return o;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - control FSM sequencing header, payload, full-stall and parity loads
module router_fsm
    import router_pkg::*;
#(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [ADDR_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  fifo_empty_0,
    input  logic                  fifo_empty_1,
    input  logic                  fifo_empty_2,
    input  logic                  soft_reset_0,
    input  logic                  soft_reset_1,
    input  logic                  soft_reset_2,
    input  logic                  parity_done,
    input  logic                  low_pkt_valid,
    output logic [ADDR_WIDTH-1:0] fsm_addr,
    output logic                  detect_add,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  laf_state,
    output logic                  full_state,
    output logic                  write_enb_reg,
    output logic                  rst_int_reg,
    output logic                  busy
);

    router_state_t         r_state;
    logic [ADDR_WIDTH-1:0] r_fsm_addr;
    logic                  w_hdr_empty;
    logic                  w_sel_empty;
    logic                  w_soft_hit;
    logic                  w_addr_valid;
    router_fsm_out_t       w_out;

    // Header decode looks at the incoming address; later states use the latched one.
    always_comb begin
        w_hdr_empty = 1'b0;
        case (data_in)
            ADDR_WIDTH'(0): w_hdr_empty = fifo_empty_0;
            ADDR_WIDTH'(1): w_hdr_empty = fifo_empty_1;
            ADDR_WIDTH'(2): w_hdr_empty = fifo_empty_2;
            default:        w_hdr_empty = 1'b0;
        endcase
    end

    always_comb begin
        w_sel_empty = 1'b0;
        w_soft_hit  = 1'b0;
        case (r_fsm_addr)
            ADDR_WIDTH'(0): begin w_sel_empty = fifo_empty_0; w_soft_hit = soft_reset_0; end
            ADDR_WIDTH'(1): begin w_sel_empty = fifo_empty_1; w_soft_hit = soft_reset_1; end
            ADDR_WIDTH'(2): begin w_sel_empty = fifo_empty_2; w_soft_hit = soft_reset_2; end
            default:        begin w_sel_empty = 1'b0;         w_soft_hit = 1'b0;         end
        endcase
    end

    assign w_addr_valid = (data_in != ADDR_WIDTH'(ADDR_INVALID));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= DECODE_ADDRESS;
            r_fsm_addr <= '0;
        end else if (w_soft_hit) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (pkt_valid) begin
                        r_fsm_addr <= data_in;
                        if (w_addr_valid)
                            r_state <= w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: r_state <= LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       r_state <= FIFO_FULL_STATE;
                    else if (!pkt_valid) r_state <= LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) r_state <= LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        r_state <= DECODE_ADDRESS;
                    else if (low_pkt_valid) r_state <= LOAD_PARITY;
                    else                    r_state <= LOAD_DATA;
                end
                LOAD_PARITY:        r_state <= CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: r_state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY: begin
                    if (w_sel_empty) r_state <= LOAD_FIRST_DATA;
                end
                default: r_state <= DECODE_ADDRESS;
            endcase
        end
    end

    assign w_out         = router_fsm_dec(r_state);
    assign fsm_addr      = r_fsm_addr;
    assign detect_add    = w_out.detect_add;
    assign lfd_state     = w_out.lfd_state;
    assign ld_state      = w_out.ld_state;
    assign laf_state     = w_out.laf_state;
    assign full_state    = w_out.full_state;
    assign write_enb_reg = w_out.write_enb_reg;
    assign rst_int_reg   = w_out.rst_int_reg;
    assign busy          = w_out.busy;

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Control FSM for the 1x3 packet router. It sequences header decode, payload load, full-stall and parity load into the three router_fifo instances. It sits between the input port and the register/synchroniser blocks. It consumes packet-valid, address and FIFO status, and drives the write enable, the `lfd_state` header marker and the busy flag.

Parameters:
ADDR_WIDTH, 2, width of destination address field (header bits [1:0]); value 3 is invalid
STATE_WIDTH, 3, encoding width of state register (8 states)

Ports:
clock  input  1  system clock, all state changes on rising edge
resetn  input  1  synchronous active-low reset
pkt_valid  input  1  high while header/payload bytes are presented; drops with the parity byte
data_in  input  ADDR_WIDTH  header address bits (data_in[1:0] of the header byte)
fifo_full  input  1  full flag of the currently selected FIFO
fifo_empty_0/1/2  input  1 each  empty flags of FIFO 0/1/2
soft_reset_0/1/2  input  1 each  per-FIFO timeout soft reset
parity_done  input  1  parity byte has been latched by the register block
low_pkt_valid  input  1  pkt_valid fell while the FSM was stalled on full
fsm_addr  output  ADDR_WIDTH  destination address latched at decode
detect_add  output  1  FSM in DECODE_ADDRESS
lfd_state  output  1  header byte being written (to router_fifo `lfd_state`)
ld_state  output  1  payload load in progress
laf_state  output  1  load-after-full cycle
full_state  output  1  stalled on full FIFO
write_enb_reg  output  1  write enable to the FIFO write-enable decode
rst_int_reg  output  1  clear internal parity registers
busy  output  1  input port must hold data

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- Reset: when resetn=0 at a clock edge, state goes to DECODE_ADDRESS and fsm_addr goes to 0. After reset, detect_add=1 and every other output is 0.
- Priority: resetn, then soft_reset_N where N==fsm_addr, then normal transitions. A matching soft reset forces DECODE_ADDRESS from any state on the next edge. A soft reset for a non-selected FIFO is ignored.
- fsm_addr is loaded from data_in only in DECODE_ADDRESS with pkt_valid=1. It is held in every other state.
- DECODE_ADDRESS:
  - pkt_valid and addr<3 and target FIFO empty: go to LOAD_FIRST_DATA.
  - pkt_valid and addr<3 and target FIFO not empty: go to WAIT_TILL_EMPTY.
  - addr==3 or !pkt_valid: stay.
- LOAD_FIRST_DATA: go to LOAD_DATA unconditionally (one cycle).
- LOAD_DATA:
  - fifo_full: go to FIFO_FULL_STATE.
  - else !pkt_valid: go to LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: go to LOAD_AFTER_FULL when fifo_full=0; else stay.
- LOAD_AFTER_FULL:
  - parity_done: go to DECODE_ADDRESS.
  - else low_pkt_valid: go to LOAD_PARITY.
  - else go to LOAD_DATA.
- LOAD_PARITY: go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full goes to FIFO_FULL_STATE; else go to DECODE_ADDRESS.
- WAIT_TILL_EMPTY: go to LOAD_FIRST_DATA when fifo_empty_[fsm_addr]=1; else stay.
- Outputs are Moore and decoded combinationally from the state register, so they respond to inputs with one cycle of latency:
  - detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA.
  - laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR.
  - write_enb_reg=LOAD_DATA|LOAD_PARITY|LOAD_AFTER_FULL.
  - busy=1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Illegal state encodings recover to DECODE_ADDRESS on the next edge.
- Simultaneous events:
  - fifo_full and !pkt_valid in LOAD_DATA: full wins.
  - parity_done and low_pkt_valid in LOAD_AFTER_FULL: parity_done wins.

Decomposition:
- Shared package router_pkg holds:
  - the state enum/localparams (8 codes, STATE_WIDTH=3);
  - ADDR_INVALID=2'b11;
  - ROUTER_NUM_FIFO=3.
- No sub-module: a single next-state block plus a state register. The output decode is optional as a router_fsm_dec function in the package.

Test Plan:
1. resetn=0 for 2 edges, then 1 with pkt_valid=0 -> detect_add=1, busy=0, all other outputs 0, state held in DECODE_ADDRESS.
2. Header data_in=2'b01, pkt_valid=1, fifo_empty_1=1, 4 payload bytes, then pkt_valid=0 -> LFD for 1 cycle, LOAD_DATA for 4, LOAD_PARITY, CHECK_PARITY_ERROR (rst_int_reg=1), DECODE; fsm_addr=1.
3. In LOAD_DATA, assert fifo_full for 3 cycles -> full_state=1, busy=1 for 3 cycles; then laf_state=1 for one cycle; with parity_done=0 and low_pkt_valid=0, returns to LOAD_DATA.
4. Header addr=2, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY, busy=1, write_enb_reg=0; on fifo_empty_2=1 -> lfd_state=1 next cycle.
5. Header addr=3 with pkt_valid=1 -> stays in DECODE_ADDRESS, no write_enb_reg, busy=0.
6. Mid-payload with fsm_addr=0: soft_reset_1=1 -> no effect; soft_reset_0=1 -> DECODE_ADDRESS next edge. resetn=0 during FIFO_FULL_STATE -> DECODE_ADDRESS and fsm_addr=0.
